// File: rtl/apple_field_if.sv
// Signals between apple_field, the game-logic block and the VGA colour mux.
interface apple_field_if #(
    parameter int unsigned BIT      = 10,
    parameter int unsigned CX       = 6,
    parameter int unsigned CY       = 6,
    parameter int unsigned N_APPLES = 2
) ();
    logic [BIT-1:0]      x_pos;
    logic [BIT-1:0]      y_pos;
    logic                frame_tick;
    logic [CX-1:0]       head_x;
    logic [CY-1:0]       head_y;
    logic                head_valid;
    logic                clear;
    logic                eaten;
    logic [7:0]          eat_count;
    logic [N_APPLES-1:0] apples_valid;
    logic                apple_active;
    logic [2:0]          rgb;

    modport master (
        output x_pos, y_pos, frame_tick, head_x, head_y, head_valid, clear,
        input  eaten, eat_count, apples_valid, apple_active, rgb
    );

    modport slave (
        input  x_pos, y_pos, frame_tick, head_x, head_y, head_valid, clear,
        output eaten, eat_count, apples_valid, apple_active, rgb
    );
endinterface

// File: rtl/apple_field.sv
// Apple manager for the snake game: LFSR placement, eat detection, respawn,
// and rendering of blinking/steady apples into the pixel stream.
module apple_field #(
    parameter int unsigned BIT          = 10,
    parameter int unsigned SIZE         = 10,
    parameter int unsigned CX           = 6,
    parameter int unsigned CY           = 6,
    parameter int unsigned GRID_W       = 64,
    parameter int unsigned GRID_H       = 48,
    parameter int unsigned N_APPLES     = 2,
    parameter int unsigned BLINK_FRAMES = 32,
    parameter logic [2:0]  COLOR        = 3'b100
) (
    input  logic          clk,
    input  logic          rst_n,
    apple_field_if.slave  bus
);
    localparam int unsigned BW        = $clog2(BLINK_FRAMES + 1);
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic {IDLE, PICK} state_t;

    state_t              state;
    state_t              state_next;

    logic [15:0]         lfsr;
    logic [CX-1:0]       ax    [N_APPLES];
    logic [CY-1:0]       ay    [N_APPLES];
    logic [BW-1:0]       blink [N_APPLES];
    logic [N_APPLES-1:0] valid;
    logic [7:0]          frame_cnt;
    logic                eaten_q;
    logic [7:0]          eat_count_q;
    logic                active_q;
    logic [2:0]          rgb_q;

    logic [CX-1:0]       cand_x;
    logic [CY-1:0]       cand_y;
    logic                cand_ok;
    logic                found;
    logic                place_c;
    logic [N_APPLES-1:0] place_sel;
    logic [N_APPLES-1:0] hit;
    logic                eat_c;
    logic [N_APPLES-1:0] valid_next;

    assign cand_x = lfsr[CX-1:0];
    assign cand_y = lfsr[CX+CY-1:CX];

    // Candidate screening, lowest free slot, eat hits and next valid mask
    always_comb begin
        cand_ok = (32'(cand_x) < GRID_W) && (32'(cand_y) < GRID_H);
        if (bus.head_valid && (cand_x == bus.head_x) && (cand_y == bus.head_y))
            cand_ok = 1'b0;
        for (int i = 0; i < int'(N_APPLES); i++) begin
            if (valid[i] && (ax[i] == cand_x) && (ay[i] == cand_y))
                cand_ok = 1'b0;
        end

        found     = 1'b0;
        place_sel = '0;
        for (int i = 0; i < int'(N_APPLES); i++) begin
            if (!valid[i] && !found) begin
                place_sel[i] = 1'b1;
                found        = 1'b1;
            end
        end
        place_c = (state == PICK) && cand_ok && found && !bus.clear;

        hit = '0;
        if (bus.frame_tick && bus.head_valid && !bus.clear) begin
            for (int i = 0; i < int'(N_APPLES); i++)
                hit[i] = valid[i] && (ax[i] == bus.head_x) && (ay[i] == bus.head_y);
        end
        eat_c = |hit;

        if (bus.clear)
            valid_next = '0;
        else
            valid_next = (valid & ~hit) | (place_c ? place_sel : '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= PICK;
        else        state <= state_next;
    end

    // Keep picking while any slot will be empty after this edge
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!(&valid_next)) state_next = PICK;
            PICK:    if (&valid_next)    state_next = IDLE;
            default: state_next = PICK;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr        <= LFSR_SEED;
            valid       <= '0;
            frame_cnt   <= '0;
            eaten_q     <= 1'b0;
            eat_count_q <= '0;
            for (int i = 0; i < int'(N_APPLES); i++) begin
                ax[i]    <= '0;
                ay[i]    <= '0;
                blink[i] <= '0;
            end
        end else begin
            lfsr    <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            valid   <= valid_next;
            eaten_q <= eat_c;
            if (bus.frame_tick)
                frame_cnt <= frame_cnt + 8'd1;
            if (bus.clear)
                eat_count_q <= '0;
            else if (eat_c && (eat_count_q != 8'hFF))
                eat_count_q <= eat_count_q + 8'd1;
            for (int i = 0; i < int'(N_APPLES); i++) begin
                if (bus.clear) begin
                    blink[i] <= '0;
                end else if (place_c && place_sel[i]) begin
                    ax[i]    <= cand_x;
                    ay[i]    <= cand_y;
                    blink[i] <= BW'(BLINK_FRAMES);
                end else if (bus.frame_tick && (blink[i] != '0)) begin
                    blink[i] <= blink[i] - BW'(1);
                end
            end
        end
    end

    // Per-apple hit box, leaving a 1-px gap on the right and bottom of each cell
    logic [BIT-1:0]      x_lo [N_APPLES];
    logic [BIT-1:0]      y_lo [N_APPLES];
    logic [N_APPLES-1:0] show;

    for (genvar g = 0; g < int'(N_APPLES); g++) begin : g_draw
        assign x_lo[g] = BIT'(ax[g]) * BIT'(SIZE);
        assign y_lo[g] = BIT'(ay[g]) * BIT'(SIZE);
        assign show[g] = valid[g]
                       && ((blink[g] == '0) || !frame_cnt[2])
                       && (bus.x_pos >= x_lo[g]) && (bus.x_pos <= x_lo[g] + BIT'(SIZE - 2))
                       && (bus.y_pos >= y_lo[g]) && (bus.y_pos <= y_lo[g] + BIT'(SIZE - 2));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            rgb_q    <= 3'b000;
        end else begin
            active_q <= |show;
            rgb_q    <= (|show) ? COLOR : 3'b000;
        end
    end

    assign bus.eaten        = eaten_q;
    assign bus.eat_count    = eat_count_q;
    assign bus.apples_valid = valid;
    assign bus.apple_active = active_q;
    assign bus.rgb          = rgb_q;
endmodule

// File: doc/apple_field.md
# apple_field

Parametrised apple manager for the snake game: holds up to `N_APPLES` apples on a cell grid, places them pseudo-randomly with a free-running LFSR, detects when the snake head eats one, and respawns it. It also renders all apples into the pixel stream, with a 1-px gap per cell and a blink animation for freshly spawned apples. It sits between the game-logic block, which supplies head position and frame tick, and the VGA colour mux, which consumes `apple_active`/`rgb`.

## Interface
- `BIT`, 10, pixel coordinate width
- `SIZE`, 10, cell size in px
- `CX`, 6, cell x width (bits)
- `CY`, 6, cell y width (bits)
- `GRID_W`, 64, grid width in cells
- `GRID_H`, 48, grid height in cells
- `N_APPLES`, 2, apple count (1..4)
- `BLINK_FRAMES`, 32, frames a new apple blinks
- `COLOR`, 3'b100, apple colour (red)

Ports:
- `clk`  in  1  pixel clock
- `rst_n`  in  1  asynchronous, active-low reset
- `x_pos`, `y_pos`  in  BIT  current beam pixel
- `frame_tick`  in  1  one-cycle pulse per frame
- `head_x`  in  CX  snake head cell x
- `head_y`  in  CY  snake head cell y
- `head_valid`  in  1  head coordinates meaningful
- `clear`  in  1  sync: drop all apples, respawn
- `eaten`  out  1  one-cycle pulse on eat
- `eat_count`  out  8  saturating eaten counter
- `apples_valid`  out  N_APPLES  per-apple valid
- `apple_active`  out  1  beam inside a visible apple (registered)
- `rgb`  out  3  `COLOR` when `apple_active`, else 3'b000

## Operation
- Reset values:
  - outputs: `eaten`=0, `eat_count`=0, `apples_valid`=0, `apple_active`=0, `rgb`=0
  - internal: LFSR=16'hACE1, FSM=PICK, blink counters=0, frame counter=0
- LFSR:
  - 16-bit Fibonacci, shifts every clock: `lfsr <= {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}`
  - never zero
- Candidate: cx=`lfsr[CX-1:0]`, cy=`lfsr[CX+CY-1:CX]`, evaluated on the current LFSR value.
- FSM states: IDLE, PICK.
- PICK, each cycle:
  - Reject the candidate if cx≥GRID_W, cy≥GRID_H, it equals any valid apple's cell, or `head_valid` and it equals (head_x, head_y).
  - Otherwise write it to the lowest-index invalid apple, set that apple valid, and load its blink counter with `BLINK_FRAMES`.
  - Stay in PICK while any apple remains invalid; else go to IDLE.
- IDLE: go to PICK on the cycle after any apple becomes invalid.
- Eat detection, only on `frame_tick` with `head_valid`:
  - For each valid apple whose cell equals the head: clear its valid bit, pulse `eaten` next cycle, add 1 to `eat_count` (saturates at 255).
  - Two apples cannot share a cell, so at most one eat per tick.
- `clear`:
  - Invalidates all apples, zeroes `eat_count` and the blink counters, FSM→PICK.
  - Takes priority over an eat or a placement in the same cycle; `eaten` is not pulsed.
- Blink:
  - Each nonzero blink counter decrements on `frame_tick`.
  - The 8-bit frame counter increments on `frame_tick`.
  - An apple with a nonzero blink counter is visible only when frame counter bit 2 is 0.
- Draw:
  - Pixel is inside apple i if x_pos ∈ [ax·SIZE, ax·SIZE+SIZE−2] and y_pos ∈ [ay·SIZE, ay·SIZE+SIZE−2]; comparisons are BIT wide.
  - `apple_active` is the registered OR over valid, visible apples.

## Timing
- Placement: one attempt per clock; accepted candidate → `apples_valid` bit set on that edge.
- Eat: `frame_tick` edge → `eaten` high for exactly one cycle on the next edge; valid bit cleared on the same edge as the `eaten` assertion.
- Respawn begins the cycle after invalidation; worst case is unbounded but statistically a few cycles.
- Draw latency: 1 clock from `x_pos`/`y_pos` to `apple_active`/`rgb`; the colour mux aligns the other layers accordingly.
- Reset asserted mid-PICK: all state returns to reset values immediately; the sequence restarts from LFSR 16'hACE1.
- A head landing on a just-placed apple in the same cycle as placement: the eat is evaluated against pre-edge valid bits, so it is not detected until the next `frame_tick`.

## Test plan
- Reset release, `head_valid`=0, defaults:
  - edge 1: candidate (33,51) rejected
  - edge 2: apple0=(3,39) valid
  - edge 3: apple1=(7,14) valid, FSM IDLE
  - `apples_valid`=2'b11
- Head=(3,39), `head_valid`=1, `frame_tick` pulse → `eaten`=1 for one cycle, `eat_count`=1, `apples_valid[0]`=0, then apple0 respawns at a cell ≠(3,39),(7,14).
- Apple0 at (3,39), steady (blink expired), beam sweep:
  - `apple_active`=1 one cycle after x∈[30,38], y∈[390,398]
  - 0 at x=39 or y=399
- Fresh apple, 32 frame_ticks:
  - visible for frame counter bit2=0, hidden for bit2=1
  - steady after 32 ticks
- 260 eats → `eat_count` holds 255; `clear` same cycle as an eat → no `eaten` pulse, count 0, both apples respawn.
- `rst_n` low during PICK, then release → identical placement sequence to the first scenario.
